// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between instruction fetch and load/store,
// issuing one transaction at a time and returning data after a fixed read latency.
module mem_port_arbiter #(
  parameter int byte_addr_p  = 32,
  parameter int mem_lat_p    = 1,
  parameter int max_streak_p = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   if_req_i,
  input  logic [byte_addr_p-1:0] if_addr_i,
  output logic                   if_gnt_o,
  output logic                   if_rvalid_o,
  output logic [31:0]            if_rdata_o,
  input  logic                   ls_req_i,
  input  logic                   ls_we_i,
  input  logic [byte_addr_p-1:0] ls_addr_i,
  input  logic [31:0]            ls_wdata_i,
  output logic                   ls_gnt_o,
  output logic                   ls_rvalid_o,
  output logic [31:0]            ls_rdata_o,
  output logic [byte_addr_p-1:0] addr_o,
  output logic                   wr_en_o,
  output logic                   rd_en_o,
  output logic [31:0]            mem_data_o,
  input  logic [31:0]            mem_data_i
);
  typedef enum logic {ST_IDLE, ST_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;

  localparam logic [2:0] MemLat    = 3'(mem_lat_p);
  localparam logic [3:0] MaxStreak = 4'(max_streak_p);

  state_e      state_q;
  owner_e      owner_q;
  logic        we_q;
  logic [2:0]  lat_q;
  logic [3:0]  streak_q, streak_d;
  logic        if_win, ls_win;
  logic        if_rvalid_q, ls_rvalid_q;
  logic [31:0] if_rdata_q, ls_rdata_q;

  // LS wins by default; IF is forced once LS has taken max_streak_p grants over it
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (state_q == ST_IDLE) begin
      if (if_req_i && (!ls_req_i || streak_q >= MaxStreak)) if_win = 1'b1;
      else if (ls_req_i)                                     ls_win = 1'b1;
    end
  end

  always_comb begin
    addr_o     = '0;
    wr_en_o    = 1'b0;
    rd_en_o    = 1'b0;
    mem_data_o = '0;
    if (if_win) begin
      addr_o  = if_addr_i;
      rd_en_o = 1'b1;
    end else if (ls_win) begin
      addr_o  = ls_addr_i;
      rd_en_o = !ls_we_i;
      wr_en_o = ls_we_i;
      if (ls_we_i) mem_data_o = ls_wdata_i;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req_i || if_win)                streak_d = '0;
    else if (ls_win && streak_q < MaxStreak) streak_d = streak_q + 4'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      we_q        <= 1'b0;
      lat_q       <= '0;
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      streak_q    <= streak_d;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (if_win || ls_win) begin
            owner_q <= if_win ? OWN_IF : OWN_LS;
            we_q    <= ls_win && ls_we_i;
            lat_q   <= MemLat;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_q == 3'd1) begin
            if (owner_q == OWN_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_data_i;
            end else if (owner_q == OWN_LS) begin
              ls_rvalid_q <= 1'b1;
              if (!we_q) ls_rdata_q <= mem_data_i;
            end
            owner_q <= OWN_NONE;
            lat_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_gnt_o    = if_win;
  assign ls_gnt_o    = ls_win;
  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for latency/reset/streak
// corners, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LAT  = 1;
  localparam int MAXS = 4;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, wr_en, rd_en;
  logic [31:0] if_rdata, ls_rdata, addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        if_req3 = 1'b0, ls_req3 = 1'b0, ls_we3 = 1'b0;
  logic [31:0] if_addr3 = '0, ls_addr3 = '0, ls_wdata3 = '0;
  logic        if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, wr_en3, rd_en3;
  logic [31:0] if_rdata3, ls_rdata3, addr3, mem_wdata3, mem_rdata3;
  logic [31:0] p3 [3];

  mem_port_arbiter #(.byte_addr_p(32), .mem_lat_p(LAT), .max_streak_p(MAXS)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .addr_o(addr), .wr_en_o(wr_en), .rd_en_o(rd_en),
    .mem_data_o(mem_wdata), .mem_data_i(mem_rdata));

  mem_port_arbiter #(.byte_addr_p(32), .mem_lat_p(LAT3), .max_streak_p(MAXS)) dut3 (
    .clk_i(clk), .rstn_i(rstn),
    .if_req_i(if_req3), .if_addr_i(if_addr3), .if_gnt_o(if_gnt3),
    .if_rvalid_o(if_rvalid3), .if_rdata_o(if_rdata3),
    .ls_req_i(ls_req3), .ls_we_i(ls_we3), .ls_addr_i(ls_addr3), .ls_wdata_i(ls_wdata3),
    .ls_gnt_o(ls_gnt3), .ls_rvalid_o(ls_rvalid3), .ls_rdata_o(ls_rdata3),
    .addr_o(addr3), .wr_en_o(wr_en3), .rd_en_o(rd_en3),
    .mem_data_o(mem_wdata3), .mem_data_i(mem_rdata3));

  function automatic logic [31:0] rdfun(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0000_0013;
      32'h0000_0200: return 32'h1234_5678;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Memory models: read data appears exactly LAT cycles after the read strobe, junk otherwise
  always @(posedge clk) mem_rdata <= rd_en ? rdfun(addr) : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    p3[0] <= rd_en3 ? rdfun(addr3) : 32'hBAD0_BAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  a_if_hold: assert property (@(posedge clk) disable iff (!rstn) (if_req && !if_gnt) |=> if_req)
    else begin
      n_fail++;
      $display("FAIL if_req_hold: if_req got 0 expected 1 (dropped before grant) at %0t", $time);
    end
  a_ls_hold: assert property (@(posedge clk) disable iff (!rstn) (ls_req && !ls_gnt) |=> ls_req)
    else begin
      n_fail++;
      $display("FAIL ls_req_hold: ls_req got 0 expected 1 (dropped before grant) at %0t", $time);
    end

  typedef struct {
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        e_ifg, e_lsg, e_rd, e_wr;
    logic [31:0] e_addr, e_wd;
    logic        e_ifrv;
    logic [31:0] e_ifrd;
    logic        e_lsrv;
    logic [31:0] e_lsrd;
  } vec_t;
  vec_t tbl [10];

  logic        g_if, g_ls;
  bit          seq_if [$];
  int          gcyc [$];
  int          ng;
  int          busy_until, streak, rv_if_at, rv_ls_at;
  logic [31:0] m_ifrd, m_lsrd, pend_if, pend_ls;
  bit          pend_ls_rd, drop_if, drop_ls, gen, eg_if, eg_ls, drained;
  logic [31:0] e_addr, e_wd;
  logic        e_rd, e_wr, e_ifrv, e_lsrv;

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rst_ls_rvalid", {31'b0, ls_rvalid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    chk("rst_cmd", {28'b0, if_gnt, ls_gnt, rd_en, wr_en}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst3_rvalid", {30'b0, if_rvalid3, ls_rvalid3}, 32'd0);
    chk("rst3_rdata", if_rdata3 | ls_rdata3, 32'd0);
    rstn = 1'b1;

    // directed vector table, lat=1
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0,
               1'b0, 32'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
               1'b0, 32'h0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100,
               32'hDEADBEEF, 1'b1, 32'h13, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
               1'b0, 32'h13, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
               1'b0, 32'h13, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0,
               1'b0, 32'h13, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
               1'b0, 32'h13, 1'b0, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0,
               1'b0, 32'h13, 1'b1, 32'h12345678};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
               1'b0, 32'h13, 1'b0, 32'h12345678};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
               1'b1, rdfun(32'h40), 1'b0, 32'h12345678};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if_req = tbl[i].if_req; ls_req = tbl[i].ls_req; ls_we = tbl[i].ls_we;
      if_addr = tbl[i].if_addr; ls_addr = tbl[i].ls_addr; ls_wdata = tbl[i].ls_wdata;
      @(negedge clk);
      chk($sformatf("vec%0d_if_gnt", i), {31'b0, if_gnt}, {31'b0, tbl[i].e_ifg});
      chk($sformatf("vec%0d_ls_gnt", i), {31'b0, ls_gnt}, {31'b0, tbl[i].e_lsg});
      chk($sformatf("vec%0d_rd_en", i), {31'b0, rd_en}, {31'b0, tbl[i].e_rd});
      chk($sformatf("vec%0d_wr_en", i), {31'b0, wr_en}, {31'b0, tbl[i].e_wr});
      chk($sformatf("vec%0d_addr", i), addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].e_wd);
      chk($sformatf("vec%0d_if_rvalid", i), {31'b0, if_rvalid}, {31'b0, tbl[i].e_ifrv});
      chk($sformatf("vec%0d_if_rdata", i), if_rdata, tbl[i].e_ifrd);
      chk($sformatf("vec%0d_ls_rvalid", i), {31'b0, ls_rvalid}, {31'b0, tbl[i].e_lsrv});
      chk($sformatf("vec%0d_ls_rdata", i), ls_rdata, tbl[i].e_lsrd);
    end

    // continuous contention: LS streak of MAXS, then IF forced; spacing LAT+1
    ng = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h80; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
    for (int k = 0; k < 100 && (if_req || ls_req); k++) begin
      @(negedge clk);
      g_if = if_gnt; g_ls = ls_gnt;
      if (g_if || g_ls) begin
        if (ng < 10) begin
          seq_if.push_back(g_if);
          gcyc.push_back(k);
        end
        ng++;
      end
      @(posedge clk); #1;
      if (ng >= 10) begin
        if (g_if) if_req = 1'b0;
        if (g_ls) ls_req = 1'b0;
      end
    end
    chk("contend_drain", {31'b0, if_req | ls_req}, 32'd0);
    chk("contend_count", {31'b0, seq_if.size() == 10}, 32'd1);
    for (int i = 0; i < seq_if.size(); i++) begin
      chk($sformatf("contend_order%0d_is_if", i), {31'b0, seq_if[i]},
          {31'b0, ((i + 1) % (MAXS + 1)) == 0});
      if (i > 0) chk($sformatf("contend_space%0d", i), gcyc[i] - gcyc[i-1], LAT + 1);
    end
    if_req = 1'b0; ls_req = 1'b0;

    // lat=3 load with IF request arriving during WAIT
    @(posedge clk); #1;
    ls_req3 = 1'b1; ls_we3 = 1'b0; ls_addr3 = 32'h200;
    @(negedge clk);
    chk("l3_T_ls_gnt", {31'b0, ls_gnt3}, 32'd1);
    chk("l3_T_rd_en", {31'b0, rd_en3}, 32'd1);
    chk("l3_T_addr", addr3, 32'h200);
    @(posedge clk); #1;
    ls_req3 = 1'b0; if_req3 = 1'b1; if_addr3 = 32'h84;
    for (int k = 1; k <= LAT3; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      chk($sformatf("l3_T%0d_strobes", k), {29'b0, rd_en3, wr_en3, if_gnt3}, 32'd0);
      chk($sformatf("l3_T%0d_ls_rvalid", k), {31'b0, ls_rvalid3}, 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("l3_T4_ls_rvalid", {31'b0, ls_rvalid3}, 32'd1);
    chk("l3_T4_ls_rdata", ls_rdata3, 32'h12345678);
    chk("l3_T4_if_gnt", {31'b0, if_gnt3}, 32'd1);
    chk("l3_T4_addr", addr3, 32'h84);
    @(posedge clk); #1;
    if_req3 = 1'b0;
    @(negedge clk);
    chk("l3_T5_ls_rvalid", {31'b0, ls_rvalid3}, 32'd0);

    // reset pulse in the middle of an IF read
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("rstmid_T_if_gnt", {31'b0, if_gnt}, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0; rstn = 1'b0;
    #1;
    chk("rstmid_if_rdata", if_rdata, 32'd0);
    chk("rstmid_ls_rdata", ls_rdata, 32'd0);
    chk("rstmid_outs", {28'b0, if_rvalid, ls_rvalid, rd_en, wr_en}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rstmid_no_rvalid%0d", k), {30'b0, if_rvalid, ls_rvalid}, 32'd0);
      @(posedge clk); #1;
    end
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("post_rst_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("post_rst_rd_en", {31'b0, rd_en}, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("post_rst_T1_rvalid", {31'b0, if_rvalid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_T2_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("post_rst_T2_rdata", if_rdata, 32'h13);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_T3_rvalid", {31'b0, if_rvalid}, 32'd0);

    // randomized traffic against a transaction-level model
    do_reset();
    busy_until = 0; streak = 0; rv_if_at = -1; rv_ls_at = -1;
    m_ifrd = '0; m_lsrd = '0; pend_if = '0; pend_ls = '0; pend_ls_rd = 1'b0;
    drop_if = 1'b0; drop_ls = 1'b0; gen = 1'b1; drained = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (drop_if) if_req = 1'b0;
      if (drop_ls) ls_req = 1'b0;
      drop_if = 1'b0; drop_ls = 1'b0;
      if (gen) begin
        if (!if_req && $urandom_range(0, 3) != 0) begin
          if_req = 1'b1; if_addr = $urandom;
        end
        if (!ls_req && $urandom_range(0, 2) != 0) begin
          ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1));
          ls_addr = $urandom; ls_wdata = $urandom;
        end
      end
      @(negedge clk);
      e_ifrv = (cyc == rv_if_at);
      e_lsrv = (cyc == rv_ls_at);
      if (e_ifrv) m_ifrd = pend_if;
      if (e_lsrv && pend_ls_rd) m_lsrd = pend_ls;
      eg_if = 1'b0; eg_ls = 1'b0;
      if (cyc >= busy_until) begin
        if (if_req && ls_req) begin
          if (streak >= MAXS) eg_if = 1'b1;
          else                eg_ls = 1'b1;
        end else if (if_req) eg_if = 1'b1;
        else if (ls_req)     eg_ls = 1'b1;
      end
      e_addr = eg_if ? if_addr : (eg_ls ? ls_addr : 32'h0);
      e_rd   = eg_if || (eg_ls && !ls_we);
      e_wr   = eg_ls && ls_we;
      e_wd   = (eg_ls && ls_we) ? ls_wdata : 32'h0;
      chk("rnd_if_gnt", {31'b0, if_gnt}, {31'b0, eg_if});
      chk("rnd_ls_gnt", {31'b0, ls_gnt}, {31'b0, eg_ls});
      chk("rnd_rd_en", {31'b0, rd_en}, {31'b0, e_rd});
      chk("rnd_wr_en", {31'b0, wr_en}, {31'b0, e_wr});
      chk("rnd_addr", addr, e_addr);
      chk("rnd_wdata", mem_wdata, e_wd);
      chk("rnd_if_rvalid", {31'b0, if_rvalid}, {31'b0, e_ifrv});
      chk("rnd_ls_rvalid", {31'b0, ls_rvalid}, {31'b0, e_lsrv});
      chk("rnd_if_rdata", if_rdata, m_ifrd);
      chk("rnd_ls_rdata", ls_rdata, m_lsrd);
      if (eg_if) begin
        pend_if = rdfun(if_addr);
        rv_if_at = cyc + LAT + 1;
        busy_until = cyc + LAT + 1;
        drop_if = 1'b1;
      end
      if (eg_ls) begin
        pend_ls = rdfun(ls_addr);
        pend_ls_rd = !ls_we;
        rv_ls_at = cyc + LAT + 1;
        busy_until = cyc + LAT + 1;
        drop_ls = 1'b1;
      end
      if (!if_req || eg_if)             streak = 0;
      else if (eg_ls && streak < MAXS)  streak = streak + 1;
      if (cyc >= 400) gen = 1'b0;
      if (!gen && !if_req && !ls_req && !drop_if && !drop_ls && cyc > busy_until) begin
        drained = 1'b1;
        break;
      end
    end
    chk("rnd_drained", {31'b0, drained}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
